// File: rtl/c1541_track_loader_if.sv
// SD block-side handshake of the track loader: one 256-byte sector per request.
interface c1541_track_loader_if;
   logic [31:0] sd_lba;
   logic        sd_rd;
   logic        sd_wr;
   logic        sd_ack;
   logic [4:0]  sd_buff_sector;

   // The loader issues requests and addresses; the SD side answers with ack.
   modport master (
      output sd_lba, sd_rd, sd_wr, sd_buff_sector,
      input  sd_ack
   );

   modport slave (
      input  sd_lba, sd_rd, sd_wr, sd_buff_sector,
      output sd_ack
   );
endinterface

// File: rtl/c1541_track_loader.sv
// Moves whole D64 tracks between the SD block interface and the GCR track
// buffer: writes back a dirty track, then reads the newly requested one.
module c1541_track_loader #(
   parameter int SETTLE = 1000
) (
   input  logic                        clk,
   input  logic                        reset,
   input  logic                        img_mounted,
   input  logic                        img_readonly,
   input  logic [5:0]                  track,
   input  logic                        gcr_we,
   output logic                        busy,
   c1541_track_loader_if.master        sd
);

   typedef enum logic [2:0] {
      S_IDLE, S_SETTLE, S_WB_REQ, S_WB_WAIT, S_RD_REQ, S_RD_WAIT
   } state_t;

   localparam int CW = $clog2(SETTLE + 1);
   localparam logic [CW-1:0] SETTLE_LAST = CW'(SETTLE - 1);

   state_t         state;
   logic [5:0]     cur_track;
   logic [5:0]     settle_track;
   logic [CW-1:0]  settle_cnt;
   logic [4:0]     sec;
   logic           loaded;
   logic           mounted;
   logic           dirty;
   logic           mount_pend;

   logic [5:0]     eff_track;
   logic [4:0]     cur_sec_last;
   logic [31:0]    cur_start;

   // Sectors per track for the four D64 speed zones.
   function automatic logic [4:0] track_spt(input logic [5:0] t);
      if (t <= 6'd17)      track_spt = 5'd21;
      else if (t <= 6'd24) track_spt = 5'd19;
      else if (t <= 6'd30) track_spt = 5'd18;
      else                 track_spt = 5'd17;
   endfunction

   // Absolute index of the first 256-byte sector of a track in the image.
   function automatic logic [31:0] track_start(input logic [5:0] t);
      logic [31:0] tw;
      tw = 32'(t);
      if (t <= 6'd17)      track_start = (tw - 32'd1) * 32'd21;
      else if (t <= 6'd24) track_start = 32'd357 + (tw - 32'd18) * 32'd19;
      else if (t <= 6'd30) track_start = 32'd490 + (tw - 32'd25) * 32'd18;
      else                 track_start = 32'd598 + (tw - 32'd31) * 32'd17;
   endfunction

   // Clamp the requested track into the legal 1..35 range.
   always_comb begin
      eff_track = track;
      if (track == 6'd0)       eff_track = 6'd1;
      else if (track > 6'd35)  eff_track = 6'd35;
   end

   assign cur_sec_last = track_spt(cur_track) - 5'd1;
   assign cur_start    = track_start(cur_track);

   // Track loader FSM with registered SD requests, addresses and busy.
   // NOTE: every register here is assigned with <= so all updates in a cycle
   // see the same pre-edge values; later assignments in the block take priority.
   always_ff @(posedge clk) begin
      if (reset) begin
         state              <= S_IDLE;
         cur_track          <= '0;
         settle_track       <= '0;
         settle_cnt         <= '0;
         sec                <= '0;
         loaded             <= 1'b0;
         mounted            <= 1'b0;
         dirty              <= 1'b0;
         mount_pend         <= 1'b0;
         busy               <= 1'b1;
         sd.sd_rd           <= 1'b0;
         sd.sd_wr           <= 1'b0;
         sd.sd_lba          <= '0;
         sd.sd_buff_sector  <= '0;
      end else begin
         // Dirty marking only counts while a valid track is idle in the buffer;
         // a read-only image never keeps anything to write back.
         if (img_readonly)
            dirty <= 1'b0;
         else if (gcr_we && loaded && state == S_IDLE)
            dirty <= 1'b1;

         // A mount arriving mid-transfer waits until the transfer finishes.
         if (img_mounted && state inside {S_WB_REQ, S_WB_WAIT, S_RD_REQ, S_RD_WAIT})
            mount_pend <= 1'b1;

         case (state)
            S_IDLE: begin
               if (img_mounted || mount_pend) begin
                  mounted      <= 1'b1;
                  loaded       <= 1'b0;
                  dirty        <= 1'b0;
                  mount_pend   <= 1'b0;
                  busy         <= 1'b1;
                  settle_cnt   <= '0;
                  settle_track <= eff_track;
                  state        <= S_SETTLE;
               end else if (mounted && eff_track != cur_track) begin
                  busy         <= 1'b1;
                  settle_cnt   <= '0;
                  settle_track <= eff_track;
                  state        <= S_SETTLE;
               end
            end

            S_SETTLE: begin
               if (img_mounted) begin
                  // New image before any transfer started: drop the old dirty data.
                  mounted      <= 1'b1;
                  loaded       <= 1'b0;
                  dirty        <= 1'b0;
                  settle_cnt   <= '0;
                  settle_track <= eff_track;
               end else if (eff_track != settle_track) begin
                  settle_cnt   <= '0;
                  settle_track <= eff_track;
               end else if (settle_cnt == SETTLE_LAST) begin
                  loaded <= 1'b0;
                  sec    <= '0;
                  if (dirty && !img_readonly) begin
                     state <= S_WB_REQ;
                  end else begin
                     cur_track <= eff_track;
                     state     <= S_RD_REQ;
                  end
               end else begin
                  settle_cnt <= settle_cnt + 1'b1;
               end
            end

            S_WB_REQ: begin
               if (sd.sd_wr && sd.sd_ack) begin
                  sd.sd_wr <= 1'b0;
                  state    <= S_WB_WAIT;
               end else begin
                  sd.sd_wr          <= 1'b1;
                  sd.sd_lba         <= cur_start + 32'(sec);
                  sd.sd_buff_sector <= sec;
               end
            end

            S_WB_WAIT: begin
               if (!sd.sd_ack) begin
                  if (sec == cur_sec_last) begin
                     dirty     <= 1'b0;
                     cur_track <= eff_track;
                     sec       <= '0;
                     state     <= S_RD_REQ;
                  end else begin
                     sec   <= sec + 5'd1;
                     state <= S_WB_REQ;
                  end
               end
            end

            S_RD_REQ: begin
               if (sd.sd_rd && sd.sd_ack) begin
                  sd.sd_rd <= 1'b0;
                  state    <= S_RD_WAIT;
               end else begin
                  sd.sd_rd          <= 1'b1;
                  sd.sd_lba         <= cur_start + 32'(sec);
                  sd.sd_buff_sector <= sec;
               end
            end

            S_RD_WAIT: begin
               if (!sd.sd_ack) begin
                  if (sec == cur_sec_last) begin
                     loaded <= 1'b1;
                     busy   <= 1'b0;
                     state  <= S_IDLE;
                  end else begin
                     sec   <= sec + 5'd1;
                     state <= S_RD_REQ;
                  end
               end
            end

            default: state <= S_IDLE;
         endcase
      end
   end

endmodule

// File: tb/tb_c1541_track_loader.sv
// Directed bench for c1541_track_loader: an SD responder pops expected
// sector requests from a scoreboard queue filled by the stimulus sequence.
module tb_c1541_track_loader;

   localparam int SETTLE = 16;

   typedef struct packed {
      logic        wr;
      logic [31:0] lba;
      logic [4:0]  bsec;
   } xfer_t;

   logic       clk = 1'b0;
   logic       reset;
   logic       img_mounted;
   logic       img_readonly;
   logic [5:0] track;
   logic       gcr_we;
   logic       busy;

   c1541_track_loader_if sd ();

   c1541_track_loader #(.SETTLE(SETTLE)) dut (
      .clk          (clk),
      .reset        (reset),
      .img_mounted  (img_mounted),
      .img_readonly (img_readonly),
      .track        (track),
      .gcr_we       (gcr_we),
      .busy         (busy),
      .sd           (sd.master)
   );

   always #5 clk = ~clk;

   xfer_t exp_q[$];
   int    errors    = 0;
   int    checks    = 0;
   int    req_count = 0;
   int    both_cnt  = 0;
   int    hold_err  = 0;

   task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
      checks++;
      assert (obs === exp) else begin
         errors++;
         $error("FAIL %s: observed=%0h expected=%0h", tag, obs, exp);
      end
   endtask

   task automatic push_seq(input logic wr, input int unsigned start, input int n);
      for (int i = 0; i < n; i++)
         exp_q.push_back(xfer_t'{wr: wr, lba: 32'(start + i), bsec: 5'(i)});
   endtask

   task automatic wait_idle(input string tag);
      bit done;
      done = 1'b0;
      for (int i = 0; i < 4000; i++) begin
         @(negedge clk);
         if (exp_q.size() == 0 && !busy && !sd.sd_ack) begin
            done = 1'b1;
            break;
         end
      end
      check({tag, "_done"}, 64'(done), 64'd1);
      check({tag, "_left"}, 64'(exp_q.size()), 64'd0);
   endtask

   // Requests must never overlap.
   always @(negedge clk)
      if (sd.sd_rd && sd.sd_wr) both_cnt++;

   // SD responder: acks 3 cycles after seeing a request, holds ack 2 cycles,
   // and checks every request against the scoreboard.
   initial begin
      xfer_t obs, exp;
      logic  ended_by_reset;
      sd.sd_ack = 1'b0;
      forever begin
         @(negedge clk);
         if (!reset && (sd.sd_rd || sd.sd_wr) && !sd.sd_ack) begin
            req_count++;
            obs = xfer_t'{wr: sd.sd_wr, lba: sd.sd_lba, bsec: sd.sd_buff_sector};
            exp = (exp_q.size() > 0) ? exp_q.pop_front() : '1;
            check("sd_req", 64'(obs), 64'(exp));
            ended_by_reset = 1'b0;
            for (int i = 0; i < 5; i++) begin
               @(negedge clk);
               if (reset) begin
                  ended_by_reset = 1'b1;
                  break;
               end
               if (sd.sd_lba !== obs.lba || sd.sd_buff_sector !== obs.bsec) hold_err++;
               if (i <= 1 && !(sd.sd_rd || sd.sd_wr)) hold_err++;
               if (i >= 3 && (sd.sd_rd || sd.sd_wr)) hold_err++;
               if (i == 2) sd.sd_ack = 1'b1;
            end
            sd.sd_ack = 1'b0;
            if (!ended_by_reset && exp_q.size() == 0 && !exp.wr) begin
               check("busy_before_last_drop", 64'(busy), 64'd1);
               @(negedge clk);
               check("busy_after_last_drop", 64'(busy), 64'd0);
            end
         end
      end
   end

   initial begin
      int  snap;
      bit  hit;
      reset        = 1'b1;
      img_mounted  = 1'b0;
      img_readonly = 1'b0;
      track        = 6'd18;
      gcr_we       = 1'b0;

      // Reset state
      repeat (3) @(negedge clk);
      check("rst_busy",   64'(busy), 64'd1);
      check("rst_rd",     64'(sd.sd_rd), 64'd0);
      check("rst_wr",     64'(sd.sd_wr), 64'd0);
      check("rst_lba",    64'(sd.sd_lba), 64'd0);
      check("rst_bsec",   64'(sd.sd_buff_sector), 64'd0);
      check("rst_track",  64'(dut.cur_track), 64'd0);
      @(negedge clk);
      reset = 1'b0;

      // Unmounted: no activity at all
      repeat (40) @(negedge clk);
      check("unmounted_reqs", 64'(req_count), 64'd0);

      // Mount and first load of track 18
      push_seq(1'b0, 357, 19);
      img_mounted = 1'b1;
      @(negedge clk);
      img_mounted = 1'b0;
      wait_idle("mount18");
      check("mount18_track", 64'(dut.cur_track), 64'd18);

      // Dirty write-back on a step from track 1 to 2
      push_seq(1'b0, 0, 21);
      track = 6'd1;
      wait_idle("load1");
      gcr_we = 1'b1;
      @(negedge clk);
      gcr_we = 1'b0;
      check("dirty_set", 64'(dut.dirty), 64'd1);
      push_seq(1'b1, 0, 21);
      push_seq(1'b0, 21, 21);
      track = 6'd2;
      wait_idle("wb_step2");
      check("wb_dirty_clr", 64'(dut.dirty), 64'd0);
      check("wb_track", 64'(dut.cur_track), 64'd2);

      // Read-only image: no write-back
      img_readonly = 1'b1;
      push_seq(1'b0, 0, 21);
      track = 6'd1;
      wait_idle("ro_load1");
      gcr_we = 1'b1;
      @(negedge clk);
      gcr_we = 1'b0;
      check("ro_dirty", 64'(dut.dirty), 64'd0);
      push_seq(1'b0, 21, 21);
      track = 6'd2;
      wait_idle("ro_step2");
      img_readonly = 1'b0;

      // Settle filtering
      push_seq(1'b0, 395, 19);
      track = 6'd20;
      wait_idle("load20");
      snap = req_count;
      for (int k = 0; k < 4; k++) begin
         track = (k % 2 == 0) ? 6'd21 : 6'd20;
         repeat (SETTLE / 2) @(negedge clk);
      end
      check("settle_no_req", 64'(req_count - snap), 64'd0);
      check("settle_busy", 64'(busy), 64'd1);
      push_seq(1'b0, 414, 19);
      track = 6'd21;
      wait_idle("settle21");

      // Clamping
      push_seq(1'b0, 0, 21);
      track = 6'd0;
      wait_idle("clamp0");
      check("clamp0_track", 64'(dut.cur_track), 64'd1);
      push_seq(1'b0, 666, 17);
      track = 6'd40;
      wait_idle("clamp40");
      check("clamp40_track", 64'(dut.cur_track), 64'd35);

      // Reset during RD_WAIT of sector 5
      push_seq(1'b0, 0, 21);
      track = 6'd1;
      hit = 1'b0;
      for (int i = 0; i < 2000; i++) begin
         @(negedge clk);
         if (sd.sd_ack && !sd.sd_rd && sd.sd_buff_sector == 5'd5) begin
            hit = 1'b1;
            break;
         end
      end
      check("midrst_reached", 64'(hit), 64'd1);
      reset = 1'b1;
      exp_q.delete();
      @(negedge clk);
      check("midrst_rd",    64'(sd.sd_rd), 64'd0);
      check("midrst_wr",    64'(sd.sd_wr), 64'd0);
      check("midrst_busy",  64'(busy), 64'd1);
      check("midrst_track", 64'(dut.cur_track), 64'd0);
      reset = 1'b0;
      snap = req_count;
      repeat (60) @(negedge clk);
      check("midrst_quiet", 64'(req_count - snap), 64'd0);
      push_seq(1'b0, 0, 21);
      img_mounted = 1'b1;
      @(negedge clk);
      img_mounted = 1'b0;
      wait_idle("remount1");

      check("never_both", 64'(both_cnt), 64'd0);
      check("addr_hold",  64'(hold_err), 64'd0);

      $display("Result: errors=%0d of %0d checks", errors, checks);
      $finish;
   end

   // Absolute time bound so the run always ends.
   initial begin
      #2000000;
      errors++;
      $display("FAIL timeout: simulation did not finish");
      $display("Result: errors=%0d of %0d checks", errors, checks);
      $fatal(1, "timeout");
   end

endmodule
